// File: rtl/alu_ctrl_sequencer.sv
// Multi-cycle control sequencer sitting in front of the datapath ALU.
// Walks each instruction through fetch (T0-T2) and execute (T3-T5), emitting
// the bus/register strobes and the ALU op code. All outputs are Moore outputs
// decoded from registered state, so they are stable for the whole cycle.
module alu_ctrl_sequencer #(
    parameter int OP_W    = 5,
    parameter int IR_W    = 32,
    parameter int OPC_MSB = 31
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    input  logic            mem_ready,
    input  logic [IR_W-1:0] ir,
    output logic [OP_W-1:0] alu_op,
    output logic            inc_pc,
    output logic            pc_out,
    output logic            pc_in,
    output logic            mar_in,
    output logic            mem_read,
    output logic            mdr_in,
    output logic            mdr_out,
    output logic            ir_in,
    output logic            y_in,
    output logic            z_in,
    output logic            zlow_out,
    output logic            gra,
    output logic            grb,
    output logic            grc,
    output logic            r_in,
    output logic            r_out,
    output logic            busy,
    output logic            illegal,
    output logic [2:0]      step
);

    // The state encoding doubles as the externally visible step code.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_T0      = 3'd1,
        S_T1      = 3'd2,
        S_T2      = 3'd3,
        S_T3      = 3'd4,
        S_T4      = 3'd5,
        S_T5      = 3'd6,
        S_ILLEGAL = 3'd7
    } state_t;

    localparam logic [OP_W-1:0] OPC_NOP = OP_W'(7);
    localparam logic [OP_W-1:0] ALU_ADD = OP_W'(2);

    state_t          state;
    state_t          state_next;
    logic [OP_W-1:0] opcode;
    logic [OP_W-1:0] opc_q;
    logic            illegal_q;
    logic            unused_ir;

    assign opcode = ir[OPC_MSB -: OP_W];

    // Only the opcode field is decoded; fold the whole IR so no bit is left dangling.
    assign unused_ir = ^ir;

    // State register, latched opcode for T4 and the sticky illegal flag.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (reset) begin
            state     <= S_IDLE;
            opc_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state <= state_next;
            // Capture the opcode while it is being decoded so T4 drives the
            // ALU from registered state, not from whatever IR holds later.
            if (state == S_T3) begin
                opc_q <= opcode;
                if (opcode > OPC_NOP) begin
                    illegal_q <= 1'b1;
                end
            end
        end
    end

    // Next-state selection and Moore output decode for the current state.
    always_comb begin
        // NOTE: every output gets a default before the case so that no path
        // leaves a signal unassigned, which would otherwise infer a latch.
        state_next = state;
        alu_op     = '0;
        inc_pc     = 1'b0;
        pc_out     = 1'b0;
        pc_in      = 1'b0;
        mar_in     = 1'b0;
        mem_read   = 1'b0;
        mdr_in     = 1'b0;
        mdr_out    = 1'b0;
        ir_in      = 1'b0;
        y_in       = 1'b0;
        z_in       = 1'b0;
        zlow_out   = 1'b0;
        gra        = 1'b0;
        grb        = 1'b0;
        grc        = 1'b0;
        r_in       = 1'b0;
        r_out      = 1'b0;
        busy       = 1'b1;

        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (run) begin
                    state_next = S_T0;
                end
            end
            S_T0: begin
                // PC -> MAR while the ALU computes PC + 1 into Z.
                pc_out     = 1'b1;
                mar_in     = 1'b1;
                inc_pc     = 1'b1;
                z_in       = 1'b1;
                alu_op     = ALU_ADD;
                state_next = S_T1;
            end
            S_T1: begin
                // Z -> PC and start the memory read; repeats until memory answers.
                zlow_out = 1'b1;
                pc_in    = 1'b1;
                mem_read = 1'b1;
                mdr_in   = 1'b1;
                if (mem_ready) begin
                    state_next = S_T2;
                end
            end
            S_T2: begin
                mdr_out    = 1'b1;
                ir_in      = 1'b1;
                state_next = S_T3;
            end
            S_T3: begin
                if (opcode < OPC_NOP) begin
                    grb        = 1'b1;
                    r_out      = 1'b1;
                    y_in       = 1'b1;
                    state_next = S_T4;
                end else if (opcode == OPC_NOP) begin
                    state_next = run ? S_T0 : S_IDLE;
                end else begin
                    state_next = S_ILLEGAL;
                end
            end
            S_T4: begin
                // Unary ops still present Rc on the bus; the ALU ignores B.
                grc        = 1'b1;
                r_out      = 1'b1;
                z_in       = 1'b1;
                alu_op     = opc_q;
                state_next = S_T5;
            end
            S_T5: begin
                zlow_out   = 1'b1;
                gra        = 1'b1;
                r_in       = 1'b1;
                state_next = run ? S_T0 : S_IDLE;
            end
            S_ILLEGAL: begin
                busy = 1'b0;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign illegal = illegal_q;
    assign step    = state;

endmodule

// File: tb/tb_alu_ctrl_sequencer.sv
// Self-checking bench for alu_ctrl_sequencer: directed stimulus with literal
// expectations plus a per-cycle comparison against a behavioural model.
module tb_alu_ctrl_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        mem_ready;
    logic [31:0] ir;
    logic [4:0]  alu_op;
    logic        inc_pc, pc_out, pc_in, mar_in, mem_read, mdr_in, mdr_out, ir_in;
    logic        y_in, z_in, zlow_out, gra, grb, grc, r_in, r_out;
    logic        busy, illegal;
    logic [2:0]  step;

    int total = 0;
    int bad   = 0;

    alu_ctrl_sequencer #(.OP_W(5), .IR_W(32), .OPC_MSB(31)) dut (
        .clk      (clk),
        .reset    (reset),
        .run      (run),
        .mem_ready(mem_ready),
        .ir       (ir),
        .alu_op   (alu_op),
        .inc_pc   (inc_pc),
        .pc_out   (pc_out),
        .pc_in    (pc_in),
        .mar_in   (mar_in),
        .mem_read (mem_read),
        .mdr_in   (mdr_in),
        .mdr_out  (mdr_out),
        .ir_in    (ir_in),
        .y_in     (y_in),
        .z_in     (z_in),
        .zlow_out (zlow_out),
        .gra      (gra),
        .grb      (grb),
        .grc      (grc),
        .r_in     (r_in),
        .r_out    (r_out),
        .busy     (busy),
        .illegal  (illegal),
        .step     (step)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: phase names tracked as plain integers.
    localparam int P_IDLE = 0, P_FETCH_PC = 1, P_FETCH_MEM = 2, P_FETCH_IR = 3;
    localparam int P_DECODE = 4, P_EXEC = 5, P_WRITE = 6, P_BAD = 7;

    int         m_phase = P_IDLE;
    logic       m_ill   = 1'b0;
    logic [4:0] m_opc   = 5'd0;
    bit         m_ok    = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_phase = P_IDLE;
            m_ill   = 1'b0;
            m_ok    = 1'b1;
        end else if (m_ok) begin
            case (m_phase)
                P_IDLE:      m_phase = run ? P_FETCH_PC : P_IDLE;
                P_FETCH_PC:  m_phase = P_FETCH_MEM;
                P_FETCH_MEM: m_phase = mem_ready ? P_FETCH_IR : P_FETCH_MEM;
                P_FETCH_IR:  m_phase = P_DECODE;
                P_DECODE: begin
                    m_opc = ir[31:27];
                    if (m_opc < 5'd7) m_phase = P_EXEC;
                    else if (m_opc == 5'd7) m_phase = run ? P_FETCH_PC : P_IDLE;
                    else begin
                        m_phase = P_BAD;
                        m_ill   = 1'b1;
                    end
                end
                P_EXEC:  m_phase = P_WRITE;
                P_WRITE: m_phase = run ? P_FETCH_PC : P_IDLE;
                default: m_phase = P_BAD;
            endcase
        end
    end

    // Per-cycle compare of every output against the model, plus the bus rule.
    always @(negedge clk) begin
        if (m_ok) begin
            logic        alu_dec;
            logic [15:0] exp_s, act_s;
            logic [4:0]  exp_op;
            alu_dec = (m_phase == P_DECODE) && (ir[31:27] < 5'd7);
            exp_s = {m_phase == P_FETCH_PC,                        // pc_out
                     m_phase == P_FETCH_MEM,                       // pc_in
                     m_phase == P_FETCH_PC,                        // mar_in
                     m_phase == P_FETCH_MEM,                       // mem_read
                     m_phase == P_FETCH_MEM,                       // mdr_in
                     m_phase == P_FETCH_IR,                        // mdr_out
                     m_phase == P_FETCH_IR,                        // ir_in
                     alu_dec,                                      // y_in
                     m_phase == P_FETCH_PC || m_phase == P_EXEC,   // z_in
                     m_phase == P_FETCH_MEM || m_phase == P_WRITE, // zlow_out
                     m_phase == P_WRITE,                           // gra
                     alu_dec,                                      // grb
                     m_phase == P_EXEC,                            // grc
                     m_phase == P_WRITE,                           // r_in
                     alu_dec || m_phase == P_EXEC,                 // r_out
                     m_phase == P_FETCH_PC};                       // inc_pc
            act_s = {pc_out, pc_in, mar_in, mem_read, mdr_in, mdr_out, ir_in, y_in,
                     z_in, zlow_out, gra, grb, grc, r_in, r_out, inc_pc};
            exp_op = (m_phase == P_FETCH_PC) ? 5'd2 : (m_phase == P_EXEC) ? m_opc : 5'd0;
            check("model_strobes", 32'(act_s), 32'(exp_s));
            check("model_alu_op", 32'(alu_op), 32'(exp_op));
            check("model_step", 32'(step), 32'(m_phase));
            check("model_busy", 32'(busy), 32'(m_phase != P_IDLE && m_phase != P_BAD));
            check("model_illegal", 32'(illegal), 32'(m_ill));
            check("single_bus", 32'($countones({pc_out, r_out, mdr_out, zlow_out}) <= 1), 32'd1);
        end
    end

    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    task automatic expect_step(input logic [2:0] s, input string name);
        nxt();
        check(name, 32'(step), 32'(s));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; run = 1'b0; mem_ready = 1'b1; ir = 32'h0;
        nxt();
        nxt();
        check("reset_step", 32'(step), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_illegal", 32'(illegal), 32'd0);
        check("reset_alu_op", 32'(alu_op), 32'd0);
        reset = 1'b0;
        expect_step(3'd0, "idle_hold");

        // 1: sub instruction, no wait states
        ir = 32'h1800_0000; run = 1'b1;
        expect_step(3'd1, "t1_t0");
        check("t1_t0_alu_add", 32'(alu_op), 32'd2);
        check("t1_t0_inc_pc", 32'(inc_pc), 32'd1);
        expect_step(3'd2, "t1_t1");
        expect_step(3'd3, "t1_t2");
        expect_step(3'd4, "t1_t3");
        check("t1_t3_y_in", 32'(y_in), 32'd1);
        expect_step(3'd5, "t1_t4");
        check("t1_t4_alu_sub", 32'(alu_op), 32'd3);
        check("t1_t4_y_in", 32'(y_in), 32'd0);
        expect_step(3'd6, "t1_t5");
        check("t1_t5_r_in", 32'(r_in), 32'd1);
        expect_step(3'd1, "t1_next_t0");

        // 2: memory wait states in T1
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            expect_step(3'd2, "t2_wait");
            check("t2_wait_mem_read", 32'(mem_read), 32'd1);
            if (i == 3) mem_ready = 1'b1;
        end
        expect_step(3'd3, "t2_after_wait");
        expect_step(3'd4, "t2_t3");
        expect_step(3'd5, "t2_t4");
        check("t2_t4_alu_sub", 32'(alu_op), 32'd3);
        expect_step(3'd6, "t2_t5");
        ir = 32'h3800_0000;

        // 3: nop with run dropped mid-fetch
        expect_step(3'd1, "t3_t0");
        expect_step(3'd2, "t3_t1");
        run = 1'b0;
        expect_step(3'd3, "t3_t2");
        expect_step(3'd4, "t3_t3");
        check("t3_nop_strobes", 32'({y_in, z_in, r_in}), 32'd0);
        check("t3_nop_busy", 32'(busy), 32'd1);
        expect_step(3'd0, "t3_idle");
        check("t3_idle_busy", 32'(busy), 32'd0);
        expect_step(3'd0, "t3_idle_hold");

        // 4: illegal opcode, sticky until reset
        ir = 32'hF800_0000; run = 1'b1;
        expect_step(3'd1, "t4_t0");
        expect_step(3'd2, "t4_t1");
        expect_step(3'd3, "t4_t2");
        expect_step(3'd4, "t4_t3");
        check("t4_t3_y_in", 32'(y_in), 32'd0);
        expect_step(3'd7, "t4_illegal");
        check("t4_illegal_flag", 32'(illegal), 32'd1);
        check("t4_illegal_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 10; i++) begin
            run = i[0];
            expect_step(3'd7, "t4_illegal_hold");
            check("t4_illegal_hold_flag", 32'(illegal), 32'd1);
        end
        reset = 1'b1; run = 1'b0;
        expect_step(3'd0, "t4_reset_idle");
        check("t4_reset_flag", 32'(illegal), 32'd0);
        reset = 1'b0;

        // 5: reset during T4 of an add
        ir = 32'h1000_0000; run = 1'b1;
        expect_step(3'd1, "t5_t0");
        expect_step(3'd2, "t5_t1");
        expect_step(3'd3, "t5_t2");
        expect_step(3'd4, "t5_t3");
        expect_step(3'd5, "t5_t4");
        check("t5_t4_z_in", 32'(z_in), 32'd1);
        check("t5_t4_alu_add", 32'(alu_op), 32'd2);
        reset = 1'b1;
        expect_step(3'd0, "t5_reset");
        check("t5_reset_z_in", 32'(z_in), 32'd0);
        check("t5_reset_alu_op", 32'(alu_op), 32'd0);
        reset = 1'b0;
        ir = 32'h3000_0000;
        expect_step(3'd1, "t5_restart");

        // 6: back-to-back shift-left then or
        expect_step(3'd2, "t6a_t1");
        expect_step(3'd3, "t6a_t2");
        expect_step(3'd4, "t6a_t3");
        expect_step(3'd5, "t6a_t4");
        check("t6a_alu_shl", 32'(alu_op), 32'd6);
        expect_step(3'd6, "t6a_t5");
        ir = 32'h0000_0000;
        expect_step(3'd1, "t6b_t0_direct");
        expect_step(3'd2, "t6b_t1");
        expect_step(3'd3, "t6b_t2");
        expect_step(3'd4, "t6b_t3");
        expect_step(3'd5, "t6b_t4");
        check("t6b_alu_or", 32'(alu_op), 32'd0);
        check("t6b_z_in", 32'(z_in), 32'd1);
        expect_step(3'd6, "t6b_t5");
        run = 1'b0;
        expect_step(3'd0, "t6_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
